// File: rtl/victim_select_fill_ctrl.sv
// ---------------------------------------------------------------------------
// victim_select_fill_ctrl
//
// Miss-handling stage in front of the way write mux. When a miss is accepted
// it does the following:
//   - Latches the miss address and the status of the addressed set.
//   - Picks a victim way: the lowest-index invalid way, or the tree
//     pseudo-LRU way when every way is valid.
//   - Writes the victim back if it is valid and dirty.
//   - Fetches the fill line.
//   - Presents the eviction bundle (target/dataIn/dataBackup/allocate) for
//     one cycle.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   missValid/missReady/missAddr miss request handshake (ready only in IDLE)
//   accessValid/accessWay        hit notification, updates the PLRU tree
//   wayValid/wayDirty            per-way status of the addressed set
//   wayLineAddr/wayLineData      per-way resident line address / data
//   wbValid/wbReady/wbAddr/wbData        victim writeback request
//   fillReqValid/fillReqReady/fillReqAddr fill request
//   fillRspValid/fillRspData     fill response
//   target/dataIn/dataBackup/allocate    eviction bundle to the write mux
//   busy                         controller is handling a miss
// ---------------------------------------------------------------------------
module victim_select_fill_ctrl #(
   parameter  int NUM_WAYS      = 4,
   parameter  int ADDRESS_WIDTH = 32,
   parameter  int BLOCK_SIZE    = 32,
   localparam int N             = NUM_WAYS,
   localparam int W             = $clog2(NUM_WAYS),
   localparam int AW            = ADDRESS_WIDTH,
   localparam int BB            = 8 * BLOCK_SIZE
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            missValid,
   output logic            missReady,
   input  logic [AW-1:0]   missAddr,
   input  logic            accessValid,
   input  logic [W-1:0]    accessWay,
   input  logic [N-1:0]    wayValid,
   input  logic [N-1:0]    wayDirty,
   input  logic [N*AW-1:0] wayLineAddr,
   input  logic [N*BB-1:0] wayLineData,
   output logic            wbValid,
   input  logic            wbReady,
   output logic [AW-1:0]   wbAddr,
   output logic [BB-1:0]   wbData,
   output logic            fillReqValid,
   input  logic            fillReqReady,
   output logic [AW-1:0]   fillReqAddr,
   input  logic            fillRspValid,
   input  logic [BB-1:0]   fillRspData,
   output logic [N-1:0]    target,
   output logic [BB-1:0]   dataIn,
   output logic [BB-1:0]   dataBackup,
   output logic            allocate,
   output logic            busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      WB     = 3'd2,
      FREQ   = 3'd3,
      FWAIT  = 3'd4,
      ALLOC  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     missAddr_q;
   logic [N-1:0]      valid_q, dirty_q;
   logic [N*AW-1:0]   lineAddr_q;
   logic [N*BB-1:0]   lineData_q;
   logic [W-1:0]      victimIdx_q;
   logic [N-1:0]      victimOh_q;
   logic [AW-1:0]     wbAddr_q;
   logic [BB-1:0]     wbData_q;
   logic [BB-1:0]     dataIn_q;
   logic [N-2:0]      plru_q, plru_d;

   logic              accept;
   logic              captureFill;
   logic [W-1:0]      selWay;
   logic [N-1:0]      selOh;
   logic [AW-1:0]     selAddr;
   logic [BB-1:0]     selData;
   logic              selDirty;

   // Walk the heap-ordered tree from the root. A node bit of 0 sends the walk
   // to the lower half (child 2k+1), 1 to the upper half (child 2k+2).
   function automatic logic [W-1:0] plru_victim(input logic [N-2:0] tree);
      int   node;
      logic b;
      node = 0;
      for (int l = 0; l < W; l++) begin
         b = 1'b0;
         for (int k = 0; k < N-1; k++)
            if (k == node) b = tree[k];
         node = b ? 2*node + 2 : 2*node + 1;
      end
      return W'(node - (N-1));
   endfunction

   // Each node on the accessed way's path is made to point at the other half.
   // The way index is consumed MSB first, one bit per tree level.
   function automatic logic [N-2:0] plru_touch(input logic [N-2:0] tree,
                                               input logic [W-1:0] way);
      logic [N-2:0] t;
      logic [W-1:0] path;
      int           node;
      t    = tree;
      path = way;
      node = 0;
      for (int l = 0; l < W; l++) begin
         for (int k = 0; k < N-1; k++)
            if (k == node) t[k] = ~path[W-1];
         node = path[W-1] ? 2*node + 2 : 2*node + 1;
         path = path << 1;
      end
      return t;
   endfunction

   // Victim selection from the latched set status. Iterating downwards
   // leaves the lowest-index invalid way in selWay.
   always_comb begin
      selWay = plru_victim(plru_q);
      for (int i = N-1; i >= 0; i--)
         if (!valid_q[i]) selWay = W'(i);
      selOh    = '0;
      selAddr  = '0;
      selData  = '0;
      selDirty = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (selWay == W'(i)) begin
            selOh[i] = 1'b1;
            selAddr  = lineAddr_q[i*AW +: AW];
            selData  = lineData_q[i*BB +: BB];
            selDirty = valid_q[i] & dirty_q[i];
         end
      end
   end

   // Next state and handshake outputs
   always_comb begin
      state_d      = state_q;
      missReady    = 1'b0;
      busy         = 1'b1;
      wbValid      = 1'b0;
      fillReqValid = 1'b0;
      allocate     = 1'b0;
      target       = '0;
      accept       = 1'b0;
      captureFill  = 1'b0;
      case (state_q)
         IDLE: begin
            missReady = 1'b1;
            busy      = 1'b0;
            if (missValid) begin
               accept  = 1'b1;
               state_d = SELECT;
            end
         end
         SELECT: state_d = selDirty ? WB : FREQ;
         WB: begin
            wbValid = 1'b1;
            if (wbReady) state_d = FREQ;
         end
         FREQ: begin
            fillReqValid = 1'b1;
            if (fillReqReady) state_d = FWAIT;
         end
         FWAIT: begin
            if (fillRspValid) begin
               captureFill = 1'b1;
               state_d     = ALLOC;
            end
         end
         ALLOC: begin
            allocate = 1'b1;
            target   = victimOh_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The allocation update takes priority over a hit in the same cycle.
   always_comb begin
      plru_d = plru_q;
      if (state_q == ALLOC)
         plru_d = plru_touch(plru_q, victimIdx_q);
      else if (accessValid)
         plru_d = plru_touch(plru_q, accessWay);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         plru_q  <= '0;
      end else begin
         state_q <= state_d;
         plru_q  <= plru_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         missAddr_q  <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         lineAddr_q  <= '0;
         lineData_q  <= '0;
         victimIdx_q <= '0;
         victimOh_q  <= '0;
         wbAddr_q    <= '0;
         wbData_q    <= '0;
         dataIn_q    <= '0;
      end else begin
         // Set status is snapshotted at acceptance only.
         if (accept) begin
            missAddr_q <= missAddr;
            valid_q    <= wayValid;
            dirty_q    <= wayDirty;
            lineAddr_q <= wayLineAddr;
            lineData_q <= wayLineData;
         end
         if (state_q == SELECT) begin
            victimIdx_q <= selWay;
            victimOh_q  <= selOh;
            wbAddr_q    <= selAddr;
            wbData_q    <= selData;
         end
         if (captureFill)
            dataIn_q <= fillRspData;
      end
   end

   assign wbAddr      = wbAddr_q;
   assign wbData      = wbData_q;
   assign dataBackup  = wbData_q;
   assign fillReqAddr = missAddr_q;
   assign dataIn      = dataIn_q;

endmodule

// File: tb/tb_victim_select_fill_ctrl.sv
module tb_victim_select_fill_ctrl;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int BB = 256;

   logic            clk;
   logic            reset_n;
   logic            missValid;
   logic            missReady;
   logic [AW-1:0]   missAddr;
   logic            accessValid;
   logic [1:0]      accessWay;
   logic [N-1:0]    wayValid;
   logic [N-1:0]    wayDirty;
   logic [N*AW-1:0] wayLineAddr;
   logic [N*BB-1:0] wayLineData;
   logic            wbValid;
   logic            wbReady;
   logic [AW-1:0]   wbAddr;
   logic [BB-1:0]   wbData;
   logic            fillReqValid;
   logic            fillReqReady;
   logic [AW-1:0]   fillReqAddr;
   logic            fillRspValid;
   logic [BB-1:0]   fillRspData;
   logic [N-1:0]    target;
   logic [BB-1:0]   dataIn;
   logic [BB-1:0]   dataBackup;
   logic            allocate;
   logic            busy;

   victim_select_fill_ctrl #(
      .NUM_WAYS(4), .ADDRESS_WIDTH(32), .BLOCK_SIZE(32)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .missValid(missValid), .missReady(missReady), .missAddr(missAddr),
      .accessValid(accessValid), .accessWay(accessWay),
      .wayValid(wayValid), .wayDirty(wayDirty),
      .wayLineAddr(wayLineAddr), .wayLineData(wayLineData),
      .wbValid(wbValid), .wbReady(wbReady), .wbAddr(wbAddr), .wbData(wbData),
      .fillReqValid(fillReqValid), .fillReqReady(fillReqReady), .fillReqAddr(fillReqAddr),
      .fillRspValid(fillRspValid), .fillRspData(fillRspData),
      .target(target), .dataIn(dataIn), .dataBackup(dataBackup),
      .allocate(allocate), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: PLRU tree bits per heap node, last fill data.
   bit          mtree [3];
   logic [BB-1:0] m_datain;
   logic [AW-1:0] la [4];
   logic [BB-1:0] ld [4];

   task automatic check(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BB-1:0] rand_line();
      logic [BB-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Range-halving walk: bit 0 keeps the lower half of [lo,hi).
   function automatic int tree_victim();
      int lo, hi, node, mid;
      lo = 0; hi = 4; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (!mtree[node]) begin hi = mid; node = 2*node + 1; end
         else              begin lo = mid; node = 2*node + 2; end
      end
      return lo;
   endfunction

   function automatic void touch(input int w);
      int lo, hi, node, mid;
      lo = 0; hi = 4; node = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (w < mid) begin mtree[node] = 1'b1; hi = mid; node = 2*node + 1; end
         else         begin mtree[node] = 1'b0; lo = mid; node = 2*node + 2; end
      end
   endfunction

   function automatic int model_victim(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return tree_victim();
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lines();
      for (int i = 0; i < 4; i++) begin
         wayLineAddr[i*AW +: AW] = la[i];
         wayLineData[i*BB +: BB] = ld[i];
      end
   endtask

   task automatic hit(input logic [1:0] w);
      accessValid = 1'b1;
      accessWay   = w;
      step();
      accessValid = 1'b0;
      touch(int'(w));
   endtask

   task automatic run_miss(input logic [AW-1:0] addr, input logic [3:0] v, input logic [3:0] d,
                           input int wb_wait, input int fq_wait, input int rsp_wait,
                           input logic [BB-1:0] fdata, input bit hit_alloc,
                           input logic [1:0] hit_way, input bit abort_fwait);
      int            ev;
      logic [3:0]    eoh;
      bit            need_wb;
      logic [AW-1:0] exp_wba;
      logic [BB-1:0] exp_wbd;
      ev      = model_victim(v);
      eoh     = 4'(1 << ev);
      need_wb = v[ev] & d[ev];
      exp_wba = la[ev];
      exp_wbd = ld[ev];

      check("idle_ready", missReady, 1);
      check("idle_alloc", allocate, 0);
      missValid = 1'b1; missAddr = addr; wayValid = v; wayDirty = d;
      drive_lines();
      step();
      // Status changes after acceptance must not affect the operation.
      missAddr = $urandom; wayValid = 4'($urandom); wayDirty = 4'($urandom);
      for (int i = 0; i < 4; i++) begin la[i] = $urandom; ld[i] = rand_line(); end
      drive_lines();
      check("sel_ready", missReady, 0);
      check("sel_busy", busy, 1);
      step();
      if (need_wb) begin
         for (int i = 0; i < wb_wait; i++) begin
            check("wb_valid_hold", wbValid, 1);
            check("wb_addr_hold", wbAddr, exp_wba);
            check("wb_data_hold", wbData, exp_wbd);
            step();
         end
         check("wb_valid", wbValid, 1);
         check("wb_addr", wbAddr, exp_wba);
         wbReady = 1'b1;
         step();
         wbReady = 1'b0;
      end
      check("no_wb", wbValid, 0);
      // Responses outside FWAIT must be ignored.
      fillRspValid = 1'b1;
      fillRspData  = rand_line();
      for (int i = 0; i < fq_wait; i++) begin
         check("freq_hold", fillReqValid, 1);
         check("freq_addr_hold", fillReqAddr, addr);
         check("freq_datain", dataIn, m_datain);
         step();
      end
      check("freq_valid", fillReqValid, 1);
      check("freq_addr", fillReqAddr, addr);
      fillReqReady = 1'b1;
      step();
      fillReqReady = 1'b0;
      fillRspValid = 1'b0;
      check("fwait_req", fillReqValid, 0);
      check("fwait_datain", dataIn, m_datain);
      if (abort_fwait) return;
      for (int i = 0; i < rsp_wait; i++) begin
         check("fwait_alloc", allocate, 0);
         step();
      end
      fillRspValid = 1'b1;
      fillRspData  = fdata;
      step();
      fillRspValid = 1'b0;
      missValid    = 1'b0;
      check("alloc", allocate, 1);
      check("target", target, eoh);
      check("dataIn", dataIn, fdata);
      check("dataBackup", dataBackup, exp_wbd);
      check("alloc_ready", missReady, 0);
      touch(ev);
      m_datain = fdata;
      if (hit_alloc) begin accessValid = 1'b1; accessWay = hit_way; end
      step();
      accessValid = 1'b0;
      check("post_alloc", allocate, 0);
      check("post_target", target, 0);
      check("post_ready", missReady, 1);
   endtask

   logic [BB-1:0] dval;
   logic [3:0]    rv;

   initial begin
      reset_n = 1'b0; missValid = 1'b0; missAddr = '0; accessValid = 1'b0; accessWay = '0;
      wayValid = '0; wayDirty = '0; wayLineAddr = '0; wayLineData = '0;
      wbReady = 1'b0; fillReqReady = 1'b0; fillRspValid = 1'b0; fillRspData = '0;
      for (int i = 0; i < 3; i++) mtree[i] = 1'b0;
      m_datain = '0;
      for (int i = 0; i < 4; i++) begin la[i] = '0; ld[i] = '0; end
      #3;
      check("rst_ready", missReady, 1);
      check("rst_busy", busy, 0);
      check("rst_target", target, 0);
      check("rst_alloc", allocate, 0);
      check("rst_wb", wbValid, 0);
      check("rst_freq", fillReqValid, 0);
      step();
      reset_n = 1'b1;
      step();

      // 1: all invalid -> way0, no writeback
      dval = rand_line();
      run_miss(32'h1000, 4'b0000, 4'b0000, 0, 0, 0, dval, 1'b0, 2'd0, 1'b0);

      // 2: all valid clean, hits way0 then way2 -> way1
      hit(2'd0);
      hit(2'd2);
      for (int i = 0; i < 4; i++) begin la[i] = 32'h100 * i; ld[i] = rand_line(); end
      run_miss(32'h3000, 4'b1111, 4'b0000, 0, 0, 0, rand_line(), 1'b0, 2'd0, 1'b0);

      // 3: dirty victim way1, writeback held off 3 cycles
      hit(2'd0);
      hit(2'd2);
      for (int i = 0; i < 4; i++) begin la[i] = $urandom; ld[i] = rand_line(); end
      la[1] = 32'h2000;
      run_miss(32'h4000, 4'b1111, 4'b0010, 3, 1, 2, rand_line(), 1'b0, 2'd0, 1'b0);

      // 4: way3 invalid wins over PLRU
      hit(2'd1);
      run_miss(32'h5000, 4'b0111, 4'b1111, 0, 0, 0, rand_line(), 1'b0, 2'd0, 1'b0);

      // 5: reset during FWAIT
      run_miss(32'h6000, 4'b1111, 4'b0000, 0, 0, 0, rand_line(), 1'b0, 2'd0, 1'b1);
      missValid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) mtree[i] = 1'b0;
      m_datain = '0;
      check("rst2_ready", missReady, 1);
      check("rst2_busy", busy, 0);
      check("rst2_freq", fillReqValid, 0);
      check("rst2_faddr", fillReqAddr, 0);
      check("rst2_datain", dataIn, 0);
      check("rst2_backup", dataBackup, 0);
      check("rst2_wbaddr", wbAddr, 0);
      step();
      reset_n = 1'b1;
      step();

      // 5/6: all valid -> way0, with a hit to way1 in the ALLOC cycle
      run_miss(32'h7000, 4'b1111, 4'b0000, 0, 0, 0, rand_line(), 1'b1, 2'd1, 1'b0);
      run_miss(32'h8000, 4'b1111, 4'b0000, 0, 0, 0, rand_line(), 1'b0, 2'd0, 1'b0);
      run_miss(32'h9000, 4'b1111, 4'b0000, 0, 0, 0, rand_line(), 1'b0, 2'd0, 1'b0);

      // Randomized transactions
      for (int it = 0; it < 40; it++) begin
         int nh;
         nh = $urandom_range(0, 2);
         for (int h = 0; h < nh; h++) hit(2'($urandom));
         for (int i = 0; i < 4; i++) begin la[i] = $urandom; ld[i] = rand_line(); end
         rv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
         run_miss($urandom, rv, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), rand_line(), 1'($urandom_range(0, 1)),
                  2'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
